// File: rtl/bw_io_impctl_pkg.sv
// Shared types and default constants for the DTL pull-up impedance calibration sequencer.
// Holds the sequencer state/mode/direction encodings and a small sizing helper.
package bw_io_impctl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_STROBE,
    ST_WAIT,
    ST_DECIDE
  } state_e;

  typedef enum logic {
    MODE_SAR,
    MODE_TRACK
  } mode_e;

  typedef enum logic {
    DIR_UP,
    DIR_DN
  } dir_e;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_SETTLE  = 4;
  localparam int DEF_ABV_LAT = 3;
  localparam int DEF_FILT    = 2;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bw_io_impctl_upctl_if.sv
// Sequencer <-> cell/pad-driver bundle: start/above in, pull-up code, strobe and published code out.
// The master modport is the sequencer side; the slave modport is the cell/environment side.
interface bw_io_impctl_upctl_if
  import bw_io_impctl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             start;
  logic             above;
  logic [WIDTH:1]   cbu;
  logic             sclk;
  logic [WIDTH:1]   code_out;
  logic             code_vld;
  logic             sar_done;
  logic             busy;

  modport master (
    input  start,
    input  above,
    output cbu,
    output sclk,
    output code_out,
    output code_vld,
    output sar_done,
    output busy
  );

  modport slave (
    output start,
    output above,
    input  cbu,
    input  sclk,
    input  code_out,
    input  code_vld,
    input  sar_done,
    input  busy
  );

endinterface

// File: rtl/bw_io_impctl_upctl_filt.sv
// Tracking direction filter: counts consecutive same-direction comparator results.
// step_up/step_dn are combinational "this result completes a run" flags; state advances only when en=1.
module bw_io_impctl_upctl_filt
  import bw_io_impctl_pkg::*;
#(
  parameter int FILT = DEF_FILT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  dir_e dir,
  output logic step_up,
  output logic step_dn
);

  localparam int CW = (FILT < 2) ? 1 : $clog2(FILT + 1);

  dir_e          dir_q, dir_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic          hit;

  // The stored count never reaches FILT, so the increment cannot wrap.
  assign cnt_inc = (dir == dir_q) ? (cnt_q + 1'b1) : CW'(1);
  assign hit     = (cnt_inc == CW'(FILT));
  assign step_up = hit && (dir == DIR_UP);
  assign step_dn = hit && (dir == DIR_DN);

  always_comb begin
    dir_d = dir_q;
    cnt_d = cnt_q;
    if (clr) begin
      dir_d = DIR_UP;
      cnt_d = '0;
    end else if (en) begin
      dir_d = dir;
      cnt_d = hit ? '0 : cnt_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q <= DIR_UP;
      cnt_q <= '0;
    end else begin
      dir_q <= dir_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bw_io_impctl_upctl.sv
// Pull-up impedance calibration: SAR search then filtered +/-1 tracking, one step per SETTLE+ABV_LAT+2 cycles.
// sar_done/code_out/code_vld register on the edge leaving the last SAR DECIDE; start=0 aborts to IDLE next cycle.
module bw_io_impctl_upctl
  import bw_io_impctl_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SETTLE  = DEF_SETTLE,
  parameter int ABV_LAT = DEF_ABV_LAT,
  parameter int FILT    = DEF_FILT
) (
  input  logic                  clk,
  input  logic                  global_reset_n,
  bw_io_impctl_upctl_if.master  io
);

  localparam int CNT_MAX = max2(SETTLE, ABV_LAT);
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int BW      = $clog2(WIDTH + 1);

  state_e          state_q, state_d;
  mode_e           mode_q, mode_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [WIDTH:1]  cbu_q, cbu_d;
  logic [WIDTH:1]  code_q, code_d;
  logic            vld_q, vld_d;
  logic            done_q, done_d;
  logic            sclk_q, sclk_d;
  logic            busy_q, busy_d;
  logic            pub_q, pub_d;

  logic            filt_en;
  logic            filt_clr;
  logic            step_up;
  logic            step_dn;
  dir_e            cur_dir;

  assign cur_dir = io.above ? DIR_DN : DIR_UP;

  bw_io_impctl_upctl_filt #(
    .FILT (FILT)
  ) u_filt (
    .clk     (clk),
    .rst_n   (global_reset_n),
    .clr     (filt_clr),
    .en      (filt_en),
    .dir     (cur_dir),
    .step_up (step_up),
    .step_dn (step_dn)
  );

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    cbu_d    = cbu_q;
    code_d   = code_q;
    vld_d    = vld_q;
    done_d   = 1'b0;
    sclk_d   = 1'b0;
    pub_d    = 1'b0;
    filt_en  = 1'b0;
    filt_clr = 1'b0;

    // A tracking step publishes the new code one cycle after cbu moves.
    if (pub_q) begin
      code_d = cbu_q;
    end

    if ((state_q != ST_IDLE) && !io.start) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      mode_d   = MODE_SAR;
      filt_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (io.start) begin
            state_d       = ST_SETTLE;
            cnt_d         = CW'(SETTLE - 1);
            cbu_d         = '0;
            cbu_d[WIDTH]  = 1'b1;
            bit_d         = BW'(WIDTH);
            mode_d        = MODE_SAR;
          end
        end

        ST_SETTLE: begin
          if (cnt_q == '0) begin
            state_d = ST_STROBE;
            sclk_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end

        ST_STROBE: begin
          state_d = ST_WAIT;
          cnt_d   = CW'(ABV_LAT - 1);
        end

        ST_WAIT: begin
          if (cnt_q == '0) begin
            state_d = ST_DECIDE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end

        ST_DECIDE: begin
          state_d = ST_SETTLE;
          cnt_d   = CW'(SETTLE - 1);
          if (mode_q == MODE_SAR) begin
            if (io.above) begin
              cbu_d[bit_q] = 1'b0;
            end
            if (bit_q > BW'(1)) begin
              cbu_d[bit_q - BW'(1)] = 1'b1;
              bit_d                 = bit_q - BW'(1);
            end else begin
              code_d = cbu_d;
              vld_d  = 1'b1;
              done_d = 1'b1;
              mode_d = MODE_TRACK;
            end
          end else begin
            filt_en = 1'b1;
            // At the rails the step is swallowed but the filter still clears.
            if (step_up && (cbu_q != '1)) begin
              cbu_d = cbu_q + 1'b1;
              pub_d = 1'b1;
            end else if (step_dn && (cbu_q != '0)) begin
              cbu_d = cbu_q - 1'b1;
              pub_d = 1'b1;
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge global_reset_n) begin
    if (!global_reset_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_SAR;
      cnt_q   <= '0;
      bit_q   <= BW'(WIDTH);
      cbu_q   <= '0;
      code_q  <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
      sclk_q  <= 1'b0;
      busy_q  <= 1'b0;
      pub_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      cbu_q   <= cbu_d;
      code_q  <= code_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
      sclk_q  <= sclk_d;
      busy_q  <= busy_d;
      pub_q   <= pub_d;
    end
  end

  assign io.cbu      = cbu_q;
  assign io.sclk     = sclk_q;
  assign io.code_out = code_q;
  assign io.code_vld = vld_q;
  assign io.sar_done = done_q;
  assign io.busy     = busy_q;

endmodule

// File: tb/tb_bw_io_impctl_upctl.sv
// Bench for bw_io_impctl_upctl: comparator cell model, step-level behavioural reference and per-cycle compare.
// Inputs change on negedges; outputs and the reference are compared on negedges.
module tb_bw_io_impctl_upctl;

  localparam int W       = 8;
  localparam int SETTLE  = 4;
  localparam int ABV_LAT = 3;
  localparam int FILT    = 2;
  localparam int STEP    = SETTLE + 1 + ABV_LAT + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bw_io_impctl_upctl_if #(.WIDTH(W)) dif();

  bw_io_impctl_upctl #(
    .WIDTH   (W),
    .SETTLE  (SETTLE),
    .ABV_LAT (ABV_LAT),
    .FILT    (FILT)
  ) dut (
    .clk            (clk),
    .global_reset_n (rst_n),
    .io             (dif)
  );

  int tests = 0;
  int fails = 0;
  int printed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Comparator cell: latches (cbu > tgt) on each strobe, valid ABV_LAT cycles later.
  int         tgt = 0;
  bit         force_hi = 1'b0;
  bit         glitch = 1'b0;
  bit         res = 1'b0;
  bit         tog = 1'b0;
  int         age = 100;
  int         nsclk = 0;
  logic [7:0] trials[$];

  always @(negedge clk) begin
    if (dif.sclk === 1'b1) begin
      res = force_hi ? 1'b1 : (int'(dif.cbu) > tgt);
      age = 0;
      nsclk++;
      trials.push_back(dif.cbu);
    end else if (age < 100) begin
      age++;
    end
    tog = ~tog;
    if (glitch)
      dif.above = (age == ABV_LAT + 1) ? res : tog;
    else
      dif.above = (age >= ABV_LAT && age <= ABV_LAT + 1) ? res : 1'($urandom_range(0, 1));
  end

  // Reference: one calibration step every STEP cycles, described by its phase number.
  int m_phase = 0;
  int m_bit   = W;
  int m_cbu   = 0;
  int m_code  = 0;
  int m_cnt   = 0;
  bit m_busy  = 1'b0;
  bit m_track = 1'b0;
  bit m_vld   = 1'b0;
  bit m_done  = 1'b0;
  bit m_dn    = 1'b0;
  bit m_pub   = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_bit = W; m_cbu = 0; m_code = 0; m_cnt = 0;
      m_busy = 0; m_track = 0; m_vld = 0; m_done = 0; m_dn = 0; m_pub = 0;
    end else begin
      m_done = 0;
      if (m_pub) begin
        m_code = m_cbu;
        m_pub  = 0;
      end
      if (!m_busy) begin
        if (dif.start) begin
          m_busy = 1; m_phase = 0; m_cbu = 1 << (W - 1); m_bit = W; m_track = 0;
        end
      end else if (!dif.start) begin
        m_busy = 0; m_track = 0; m_cnt = 0; m_dn = 0;
      end else if (m_phase == STEP - 1) begin
        m_phase = 0;
        if (!m_track) begin
          if (dif.above) m_cbu = m_cbu & ~(1 << (m_bit - 1));
          if (m_bit > 1) begin
            m_bit--;
            m_cbu = m_cbu | (1 << (m_bit - 1));
          end else begin
            m_code = m_cbu; m_vld = 1; m_done = 1; m_track = 1;
          end
        end else begin
          if (dif.above == m_dn) m_cnt++;
          else begin
            m_dn  = dif.above;
            m_cnt = 1;
          end
          if (m_cnt == FILT) begin
            m_cnt = 0;
            if (m_dn && m_cbu > 0) begin
              m_cbu--; m_pub = 1;
            end else if (!m_dn && m_cbu < (1 << W) - 1) begin
              m_cbu++; m_pub = 1;
            end
          end
        end
      end else begin
        m_phase++;
      end
    end
  end

  always @(negedge clk) begin
    logic [7:0] e_cbu, e_code;
    logic       e_sclk;
    e_cbu  = m_cbu[7:0];
    e_code = m_code[7:0];
    e_sclk = m_busy && (m_phase == SETTLE);
    tests++;
    if ({dif.cbu, dif.sclk, dif.code_out, dif.code_vld, dif.sar_done, dif.busy} !==
        {e_cbu, e_sclk, e_code, m_vld, m_done, m_busy}) begin
      fails++;
      if (printed < 10) begin
        printed++;
        $display("FAIL cycle t=%0t: cbu %h/%h sclk %b/%b code %h/%h vld %b/%b done %b/%b busy %b/%b (got/want)",
                 $time, dif.cbu, e_cbu, dif.sclk, e_sclk, dif.code_out, e_code,
                 dif.code_vld, m_vld, dif.sar_done, m_done, dif.busy, m_busy);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(output int dt);
    dt = 0;
    while (dif.sar_done !== 1'b1 && dt < 300) begin
      @(negedge clk);
      dt++;
    end
    if (dt >= 300) chk("sar_timeout", dt, 0);
  endtask

  initial begin
    logic [7:0] exp_seq [8];
    int dt;
    int n;
    exp_seq = '{8'h80, 8'h40, 8'h60, 8'h50, 8'h58, 8'h5C, 8'h5A, 8'h5B};

    dif.start = 1'b0;
    dif.above = 1'b0;
    rst_n = 1'b0;
    tick(3);
    chk("rst_cbu", dif.cbu, 0);
    chk("rst_sclk", dif.sclk, 0);
    chk("rst_code", dif.code_out, 0);
    chk("rst_vld", dif.code_vld, 0);
    chk("rst_busy", dif.busy, 0);
    rst_n = 1'b1;
    tick(2);

    // Clean SAR toward 0x5A.
    tgt = 'h5A; trials.delete(); nsclk = 0;
    dif.start = 1'b1;
    wait_done(dt);
    chk("sar_latency", dt, 1 + 72);
    for (int i = 0; i < 8; i++) chk("sar_trial", trials[i], exp_seq[i]);
    chk("sar_nsclk", nsclk, 8);
    chk("sar_code", dif.code_out, 'h5A);
    chk("sar_vld", dif.code_vld, 1);

    // Retarget and track.
    tgt = 'h5C;
    tick(18); chk("trk_cbu_5b", dif.cbu, 'h5B);
    tick(1);  chk("trk_code_5b", dif.code_out, 'h5B);
    tick(17); chk("trk_cbu_5c", dif.cbu, 'h5C);
    tick(1);  chk("trk_code_5c", dif.code_out, 'h5C);
    tick(17); chk("trk_cbu_5d", dif.cbu, 'h5D);
    tick(18); chk("trk_cbu_back_5c", dif.cbu, 'h5C);

    // Saturation at all-ones.
    dif.start = 1'b0; tick(2);
    tgt = 255; dif.start = 1'b1;
    wait_done(dt);
    chk("sat_hi_code", dif.code_out, 'hFF);
    tick(4 * STEP);
    chk("sat_hi_cbu", dif.cbu, 'hFF);

    // Saturation at zero.
    dif.start = 1'b0; tick(2);
    force_hi = 1'b1; dif.start = 1'b1;
    wait_done(dt);
    chk("sat_lo_code", dif.code_out, 0);
    tick(4 * STEP);
    chk("sat_lo_cbu", dif.cbu, 0);
    force_hi = 1'b0;

    // Abort during WAIT of step 3, then restart.
    dif.start = 1'b0; tick(2);
    tgt = 'h5A; dif.start = 1'b1;
    tick(24);
    dif.start = 1'b0;
    tick(1);
    chk("abort_busy", dif.busy, 0);
    chk("abort_sclk", dif.sclk, 0);
    chk("abort_cbu", dif.cbu, 'h60);
    chk("abort_vld", dif.code_vld, 1);
    tick(5);
    trials.delete();
    dif.start = 1'b1;
    wait_done(dt);
    chk("restart_first", trials[0], 'h80);
    chk("restart_code", dif.code_out, 'h5A);

    // Reset in the middle of a strobe.
    dif.start = 1'b0; tick(2);
    dif.start = 1'b1;
    n = 0;
    while (dif.sclk !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("sclk_seen", dif.sclk, 1);
    #1;
    rst_n = 1'b0;
    dif.start = 1'b0;
    #1;
    chk("arst_sclk", dif.sclk, 0);
    chk("arst_cbu", dif.cbu, 0);
    chk("arst_code", dif.code_out, 0);
    chk("arst_vld", dif.code_vld, 0);
    chk("arst_busy", dif.busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    nsclk = 0;
    tick(30);
    chk("no_sclk_after_rst", nsclk, 0);

    // Comparator glitching outside the decision cycle.
    glitch = 1'b1; tgt = 'h5A;
    dif.start = 1'b1;
    wait_done(dt);
    chk("glitch_code", dif.code_out, 'h5A);
    glitch = 1'b0;

    // Random targets, some preceded by an aborted attempt.
    for (int k = 0; k < 6; k++) begin
      dif.start = 1'b0; tick(2);
      tgt = int'($urandom_range(0, 255));
      if (k % 2 == 1) begin
        dif.start = 1'b1;
        tick(int'($urandom_range(2, 60)));
        dif.start = 1'b0;
        tick(2);
      end
      dif.start = 1'b1;
      wait_done(dt);
      chk("rand_code", dif.code_out, tgt);
      tick(int'($urandom_range(0, 40)));
    end

    dif.start = 1'b0;
    tick(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, want finish before %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/bw_io_impctl_upctl.md
# bw_io_impctl_upctl

Calibration sequencer for the DTL pull-up impedance-control cell. It drives the 8-bit pull-up code `cbu` into the cell and issues the `sclk` sample strobe. It reads back the registered comparator result `above`, which is 1 when the pad is above vref and the pull-up is too strong. It runs a binary search (SAR) followed by filtered ±1 tracking, and publishes the calibrated code to the pad drivers.

## Interface
Parameters:
- `WIDTH`, 8: code width; `cbu` and `code_out` bits are indexed [WIDTH:1].
- `SETTLE`, 4: cycles the pad is left to settle after each `cbu` change.
- `ABV_LAT`, 3: cycles from `sclk` assertion until `above` is valid.
- `FILT`, 2: number of consecutive same-direction results required for one tracking step (≥1).

Ports:
- `clk` in 1: single clock.
- `global_reset_n` in 1: reset, asynchronous, active-low.
- `start` in 1: level enable; rising while IDLE begins SAR; low aborts to IDLE.
- `above` in 1: comparator result from the cell.
- `cbu` out [WIDTH:1]: pull-up code to the cell.
- `sclk` out 1: one-cycle sample strobe to the cell.
- `code_out` out [WIDTH:1]: published calibrated code.
- `code_vld` out 1: `code_out` is valid (first SAR has completed).
- `sar_done` out 1: one-cycle pulse when SAR finishes.
- `busy` out 1: state ≠ IDLE.

## Operation
- Reset values: `cbu`=0, `sclk`=0, `code_out`=0, `code_vld`=0, `sar_done`=0, `busy`=0; state IDLE, mode SAR, bit index WIDTH, filter cleared.
- States:
  - IDLE → SETTLE on `start`=1; that edge loads `cbu`=1<<(WIDTH-1) (0x80), bit index WIDTH, mode SAR.
  - SETTLE: SETTLE cycles → STROBE.
  - STROBE: 1 cycle, `sclk`=1 → WAIT.
  - WAIT: ABV_LAT cycles → DECIDE.
  - DECIDE: 1 cycle; samples `above`; updates `cbu`; → SETTLE.
- SAR DECIDE for trial bit i:
  - If `above`=1, clear bit i; otherwise keep it.
  - If i>1, set bit i-1 and decrement i.
  - If i=1, load `code_out` with the final code, set `code_vld`=1, pulse `sar_done`, and switch mode to TRACK.
  - Result: the largest code for which `above`=0.
- TRACK DECIDE:
  - Direction is DN if `above`=1, else UP.
  - If the direction equals the stored direction, the count increments; otherwise the stored direction updates and the count becomes 1.
  - When the count reaches FILT, `cbu` steps ±1, the count clears, and `code_out` takes the new `cbu` one cycle later.
- Saturation: DN at 0 and UP at all-ones hold `cbu`; the count still clears. `code_out` is unchanged.
- `start`=0 in any non-IDLE state: next cycle IDLE and `sclk`=0. `cbu`, `code_out` and `code_vld` hold. The filter clears and mode resets to SAR.
- A new `start` always reruns a full SAR. `code_vld` stays 1 and `code_out` keeps its old value until the new SAR completes.
- `code_vld` is cleared only by reset.

## Timing
- `cbu` changes on the edge leaving DECIDE, or the IDLE→SETTLE edge.
- Step period is SETTLE+1+ABV_LAT+1 = 9 cycles at defaults.
- SAR latency: `sar_done` pulses in DECIDE of step WIDTH, i.e. 1+WIDTH·9−1 = 72 cycles after the `start` sample edge.
  - `code_out` and `code_vld` are registered on that same edge.
- `sclk` is high exactly one cycle per step and never high in IDLE.
- `above` is sampled only in DECIDE; its value in other cycles is ignored.
- Async reset forces all outputs to reset values immediately, including mid-step and mid-`sclk` pulse.

## Structure
- Package `bw_io_impctl_pkg`: state enum (IDLE, SETTLE, STROBE, WAIT, DECIDE), mode enum (SAR, TRACK), direction enum (UP, DN), default parameter constants.
- Sub-module `bw_io_impctl_upctl_filt`: the tracking direction filter (stored direction, consecutive count, step-up/step-down outputs, clear input).
- Top level: state register, shared cycle counter sized for max(SETTLE, ABV_LAT), SAR bit index, code register.

## Test plan
- Cell model `above` = (`cbu` > T), delivered ABV_LAT cycles after `sclk`. With T=0x5A and `start`=1: `cbu` trial sequence 0x80, 0x40, 0x60, 0x50, 0x58, 0x5C, 0x5A, 0x5B. Final `code_out`=0x5A, `code_vld`=1, `sar_done` pulses 72 cycles after start, 8 `sclk` pulses.
- After convergence, retarget T=0x5C with FILT=2: `cbu` reaches 0x5B after 2 DECIDEs and 0x5C after 4. It then dithers between 0x5C and 0x5D, and `code_out` follows each step.
- Saturation:
  - T=0xFF: SAR yields 0xFF; UP results in TRACK keep `cbu`=0xFF.
  - `above` forced 1: SAR yields 0x00; `cbu` holds 0x00.
- `start` dropped during WAIT of step 3: IDLE next cycle, `sclk`=0, `cbu` held, `busy`=0. Re-raising `start` restarts at 0x80.
- `global_reset_n` asserted mid-`sclk`: all outputs 0 immediately. After release, no `sclk` until `start`.
- Glitch `above` outside DECIDE (toggle every cycle): final code identical to the clean run.
